serial_subtractor32: RTL and testbench

Multi-cycle bit-sliced subtractor, the inverse companion of the team's 32-bit ripple adder: computes D = A - B - Bin with borrow out.
Processes CHUNK bits per clock, least-significant slice first, with the borrow registered between slices.
Uses a start/ready/valid handshake so datapath control logic can trade area for latency.
Sits beside the adder in the ALU datapath.

---
 rtl/serial_subtractor32_pkg.sv | 18 +
 rtl/serial_subtractor32_if.sv | 26 ++
 rtl/serial_subtractor32_sub_slice.sv | 19 +
 rtl/serial_subtractor32.sv | 109 ++++++++++
 tb/tb_serial_subtractor32.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor32_pkg.sv
// Shared ALU datapath definitions: FSM states, default sizes and the counter-width helper.
// Optional build macro used by this block: SUBTRACTOR_OVERFLOW_EN.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // Slice counter width: clog2(n), never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor32_if.sv
// Request/response bundle for the serial subtractor.
// Optional build macro: SUBTRACTOR_OVERFLOW_EN adds the signed-overflow flag V.
interface serial_subtractor32_if #(parameter int WIDTH = alu_pkg::DEF_WIDTH);

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // start while ready=0 is dropped, not queued. valid is a one-cycle pulse
  // marking new D/Bout (and V), which then hold until the next accepted start.
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             valid;
`ifdef SUBTRACTOR_OVERFLOW_EN
  logic             V;

  modport master (output start, A, B, Bin, input ready, D, Bout, valid, V);
  modport slave  (input start, A, B, Bin, output ready, D, Bout, valid, V);
`else
  modport master (output start, A, B, Bin, input ready, D, Bout, valid);
  modport slave  (input start, A, B, Bin, output ready, D, Bout, valid);
`endif

endinterface

// File: rtl/serial_subtractor32_sub_slice.sv
// Combinational W-bit subtract with borrow: {bout, d} = a - b - bin.
module sub_slice #(
  parameter int W = alu_pkg::DEF_CHUNK
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic [W:0] diff;

  // A negative result wraps with the extra top bit set, which is the borrow.
  assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign d    = diff[W-1:0];
  assign bout = diff[W];

endmodule

// File: rtl/serial_subtractor32.sv
// Multi-cycle subtractor D = A - B - Bin, CHUNK bits per clock, LSB slice first.
// Optional build macro: SUBTRACTOR_OVERFLOW_EN adds the registered signed-overflow output V.
module serial_subtractor32
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor32_if.slave bus,
  output state_t               dbg_state
);

  localparam int             N    = WIDTH / CHUNK;
  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             borrow_q, bout_q, valid_q;
  logic             accept, last;

  logic [CHUNK-1:0] a_sl, b_sl, slice_d;
  logic             slice_bout;

  // One slice unit, steered to the current chunk by the counter.
  assign a_sl = a_q[int'(cnt)*CHUNK +: CHUNK];
  assign b_sl = b_q[int'(cnt)*CHUNK +: CHUNK];

  sub_slice #(.W(CHUNK)) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state   <= state_n;
      valid_q <= last;
      if (accept) begin
        a_q      <= bus.A;
        b_q      <= bus.B;
        borrow_q <= bus.Bin;
        cnt      <= '0;
      end else if (state == RUN) begin
        d_q[int'(cnt)*CHUNK +: CHUNK] <= slice_d;
        borrow_q <= slice_bout;
        cnt      <= last ? '0 : cnt + 1'b1;
        if (last) bout_q <= slice_bout;
      end
    end
  end

`ifdef SUBTRACTOR_OVERFLOW_EN
  logic v_q;

  // Overflow only when operand signs differ and the result sign leaves A's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else if (last) begin
      v_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (slice_d[CHUNK-1] != a_q[WIDTH-1]);
    end
  end

  assign bus.V = v_q;
`endif

  assign bus.ready = (state == IDLE);
  assign bus.valid = valid_q;
  assign bus.D     = d_q;
  assign bus.Bout  = bout_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor32.sv
// Bench for serial_subtractor32: directed table, corner sequences, random stream vs. word-level model.
// Build with SUBTRACTOR_OVERFLOW_EN defined to also check V.
module tb_serial_subtractor32;
  import alu_pkg::*;

  localparam int WIDTH = DEF_WIDTH;
  localparam int CHUNK = DEF_CHUNK;
  localparam int N     = WIDTH / CHUNK;
  localparam int W     = WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor32_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor32 #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Whole-word arithmetic: unsigned difference, borrow by comparison, overflow by signed range.
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic bin);
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             v;
    longint           s;
    longint           smax;
    longint           smin;
    d    = a - b - WIDTH'(bin);
    bo   = (longint'(a) < longint'(b) + longint'(bin));
    s    = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
    smax = (longint'(1) <<< (WIDTH - 1)) - 1;
    smin = -(longint'(1) <<< (WIDTH - 1));
    v    = (s > smax) || (s < smin);
    return {v, bo, d};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         prev_valid = 1'b0;
  logic         stream_on = 1'b0;
  int           last_valid_cyc = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.start && bus.ready) exp_q.push_back(model(bus.A, bus.B, bus.Bin));
      if (bus.valid) begin
        if (prev_valid) check("valid_width", 1, 0);
        if (stream_on && last_valid_cyc >= 0) check("valid_period", 64'(cyc - last_valid_cyc), 64'(N + 1));
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_valid", 1, 0);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("sb_D", 64'(bus.D), 64'(e[WIDTH-1:0]));
          check("sb_Bout", 64'(bus.Bout), 64'(e[WIDTH]));
`ifdef SUBTRACTOR_OVERFLOW_EN
          check("sb_V", 64'(bus.V), 64'(e[WIDTH+1]));
`endif
        end
      end
      prev_valid = bus.valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    int t = 0;
    @(posedge clk); #1;
    while (!bus.ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.ready) check("ready_timeout", 0, 1);
    bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string name, output logic got);
    got = 1'b0;
    for (int i = 0; i < 4 * N + 10; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        v;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic got;
    int   lat;
    int   rdy_low;

    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0010, 32'h0000_0010, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h0234_5677, 1'b0, 32'h1000_0001, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[6] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};

    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;

    // Reset state
    #12;
    check("rst_ready", 64'(bus.ready), 1);
    check("rst_valid", 64'(bus.valid), 0);
    check("rst_D", 64'(bus.D), 0);
    check("rst_Bout", 64'(bus.Bout), 0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
`ifdef SUBTRACTOR_OVERFLOW_EN
    check("rst_V", 64'(bus.V), 0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Table: result, latency, ready-low window, single-cycle valid
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      lat = 0; rdy_low = 0; got = 1'b0;
      for (int k = 0; k < 4 * N + 10; k++) begin
        @(negedge clk);
        lat++;
        if (!bus.ready) rdy_low++;
        if (bus.valid) begin
          got = 1'b1;
          break;
        end
      end
      check($sformatf("vec%0d_got_valid", i), 64'(got), 1);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(N + 1));
      check($sformatf("vec%0d_ready_low", i), 64'(rdy_low), 64'(N));
      check($sformatf("vec%0d_D", i), 64'(bus.D), 64'(vecs[i].d));
      check($sformatf("vec%0d_Bout", i), 64'(bus.Bout), 64'(vecs[i].bout));
`ifdef SUBTRACTOR_OVERFLOW_EN
      check($sformatf("vec%0d_V", i), 64'(bus.V), 64'(vecs[i].v));
`endif
      @(negedge clk);
      check($sformatf("vec%0d_valid_drop", i), 64'(bus.valid), 0);
      check($sformatf("vec%0d_D_hold", i), 64'(bus.D), 64'(vecs[i].d));
    end

    // Start during RUN is ignored
    do_op(32'h1234_5678, 32'h0234_5677, 1'b0);
    bus.A = 32'hFFFF_FFFF; bus.B = 32'h0; bus.Bin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_valid("busy_start", got);
    check("busy_start_D", 64'(bus.D), 64'h1000_0001);
    check("busy_start_Bout", 64'(bus.Bout), 0);
    drain();

    // Start held continuously with operands changing every cycle
    last_valid_cyc = -1;
    stream_on = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.A = $urandom; bus.B = $urandom; bus.Bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    drain();
    stream_on = 1'b0;

    // Randomized operations with idle gaps
    for (int i = 0; i < 25; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a + 1;
        2: b = {1'b1, a[WIDTH-2:0]};
        default: b = $urandom;
      endcase
      do_op(a, b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, N + 2)) @(posedge clk);
    end
    drain();

    // Reset mid-RUN aborts with no valid
    do_op(32'hDEAD_BEEF, 32'h0000_0001, 1'b0);
    if (N > 1) @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_ready", 64'(bus.ready), 1);
    check("abort_valid", 64'(bus.valid), 0);
    check("abort_D", 64'(bus.D), 0);
    check("abort_Bout", 64'(bus.Bout), 0);
    @(negedge clk); rst_n = 1'b1;
    begin
      int nv = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (bus.valid) nv++;
      end
      check("abort_no_valid", 64'(nv), 0);
    end

    // Fresh operation after the abort
    do_op(32'h0000_0005, 32'h0000_0003, 1'b0);
    wait_valid("post_abort", got);
    check("post_abort_D", 64'(bus.D), 64'h2);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
